// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: byte-serial multi-precision add/subtract sequencer.
// Drives one external 8-bit carry-lookahead adder a byte at a time and
// chains the carry through a register to build NBYTES-wide results.
// Optional feature macro: CLA_SEQ_SUB_EN (enables op_sub / subtract).
module cla_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [8*NBYTES-1:0]   i_op_a,
    input  logic [8*NBYTES-1:0]   i_op_b,
    input  logic                  i_op_sub,
    output logic [7:0]            o_add_a,
    output logic [7:0]            o_add_b,
    output logic                  o_add_cin,
    input  logic [7:0]            i_add_sum,
    input  logic                  i_add_cout,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [8*NBYTES-1:0]   o_result,
    output logic                  o_carry_out,
    output logic                  o_overflow,
    output logic                  o_zero
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic [NBYTES-1:0][7:0]     r_a, r_b, r_res, w_res_nxt;
    logic [IW-1:0]              r_idx;
    logic                       r_carry, r_cout, r_ovf, r_zero;
    logic                       w_last;
    logic [8*NBYTES-1:0]        w_b_in;
    logic                       w_cin0;

`ifdef CLA_SEQ_SUB_EN
    // Subtract is A + ~B + 1; the inversion happens once at capture time.
    assign w_b_in = i_op_sub ? ~i_op_b : i_op_b;
    assign w_cin0 = i_op_sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = i_op_sub;
    assign w_b_in       = i_op_b;
    assign w_cin0       = 1'b0;
`endif

    assign w_last      = (r_idx == IW'(NBYTES - 1));
    assign o_result    = r_res;
    assign o_carry_out = r_cout;
    assign o_overflow  = r_ovf;
    assign o_zero      = r_zero;

    // Result image after this cycle's byte lands; feeds the zero flag too.
    always_comb begin
        w_res_nxt        = r_res;
        w_res_nxt[r_idx] = i_add_sum;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and handshake/adder-port outputs; adder ports idle at 0.
    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_add_a     = 8'h00;
        o_add_b     = 8'h00;
        o_add_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                o_add_a   = r_a[r_idx];
                o_add_b   = r_b[r_idx];
                o_add_cin = r_carry;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, byte accumulation, carry chaining and final flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_op_a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin0;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_nxt;
                    r_carry <= i_add_cout;
                    if (w_last) begin
                        r_cout <= i_add_cout;
                        r_ovf  <= (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) &&
                                  (i_add_sum[7] != r_a[NBYTES-1][7]);
                        r_zero <= (w_res_nxt == '0);
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: scoreboard bench for cla_seq_ctrl with a behavioral
// 8-bit adder closing the loop on the adder ports.
module tb_cla_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic          clk, rst_n;
    logic          in_valid, in_ready, op_sub;
    logic [W-1:0]  op_a, op_b, result;
    logic [7:0]    add_a, add_b, add_sum;
    logic          add_cin, add_cout;
    logic          out_valid, out_ready;
    logic          carry_out, overflow, zero;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    cla_seq_ctrl #(.NBYTES(NB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_op_sub    (op_sub),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .o_add_cin   (add_cin),
        .i_add_sum   (add_sum),
        .i_add_cout  (add_cout),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_carry_out (carry_out),
        .o_overflow  (overflow),
        .o_zero      (zero)
    );

    // external adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t        e;
        logic [W-1:0] bb;
        logic        cin;
        logic [W:0]  s;
        bb  = b;
        cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            bb  = ~b;
            cin = 1'b1;
        end
`endif
        s      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        e.zero = (s[W-1:0] == '0);
        return e;
    endfunction

    // Drive a request, wait (bounded) for the accept edge, push expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit keep);
        int waited;
        @(negedge clk);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(model(a, b, sub));
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency, pop and compare, handshake.
    task automatic expect_out(input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 50);
        if (!out_valid) begin
            chk("out_timeout", 0, 1);
            return;
        end
        chk("latency", cyc, exp_lat);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("carry_out", carry_out, e.cout);
        chk("overflow", overflow, e.ovf);
        chk("zero", zero, e.zero);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_done", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_flags"}, {carry_out, overflow, zero}, 3'b000);
        chk({tag, "_addport"}, {add_a, add_b, add_cin}, 17'h0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        #23;
        chk_reset_vals("rst");
        @(negedge clk); rst_n = 1'b1;

        // carry across byte 0 into byte 1; latency checked from accept
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("byte1_cin", add_cin, 1);
        chk("byte1_valid", out_valid, 0);
        expect_out(NB - 1);
        chk("const_ff_plus_1", result, 32'h0000_0100);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        expect_out(NB);
        chk("const_wrap_zero", {result, zero}, {32'h0, 1'b1});

        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        expect_out(NB);
        chk("const_ovf", {result, overflow}, {32'h8000_0000, 1'b1});

        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        expect_out(NB);
`ifdef CLA_SEQ_SUB_EN
        chk("const_5m7", {result, carry_out}, {32'hFFFF_FFFE, 1'b0});
        issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
        expect_out(NB);
        chk("const_7m5", {result, carry_out}, {32'h0000_0002, 1'b1});
`else
        chk("const_5p7", result, 32'h0000_000C);
`endif

        // a few random operations
        for (int i = 0; i < 4; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            expect_out(NB);
        end

        // backpressure: DONE held, second request waiting with new operands
        out_ready = 1'b0;
        issue(32'h0102_0304, 32'h0000_0010, 1'b0, 1'b1);
        op_a = 32'h0000_0100; op_b = 32'h0000_0200; op_sub = 1'b0;
        for (int k = 0; k < NB; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", out_valid, 1);
        e = (sb_q.size() != 0) ? sb_q[0] : '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_result", result, e.res);
            chk("bp_hold_flags", {carry_out, overflow, zero}, {e.cout, e.ovf, e.zero});
        end
        chk("bp_one_pending", sb_q.size(), 1);
        void'(sb_q.pop_front());
        chk("bp_result_const", result, 32'h0102_0314);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        sb_q.push_back(model(32'h0000_0100, 32'h0000_0200, 1'b0));
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", in_ready, 0);
        expect_out(NB);
        chk("bp_second_const", result, 32'h0000_0300);

        // reset during the byte-2 RUN cycle
        issue(32'h1122_3344, 32'h5566_7788, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_idx2_adda", add_a, 8'h22);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1;
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        expect_out(NB);
        chk("post_rst_const", result, 32'h0000_0030);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_seq_ctrl.md
# cla_seq_ctrl

Byte-serial multi-precision add/subtract sequencer that time-shares one external 8-bit carry-lookahead adder to compute NBYTES-wide sums. It sits between a requester using a valid/ready handshake and the combinational 8-bit adder instance. It feeds one operand byte per cycle and chains the adder's carry-out into the next byte's carry-in through a register.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. Deassertion is synchronous to clk.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op_a  in  8*NBYTES  operand A, unsigned or two's complement.
- op_b  in  8*NBYTES  operand B.
- op_sub  in  1  1 = A−B, 0 = A+B. Only effective when CLA_SEQ_SUB_EN is defined.
- add_a  out  8  adder operand A byte.
- add_b  out  8  adder operand B byte, already inverted for subtract.
- add_cin  out  1  adder carry-in.
- add_sum  in  8  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  adder carry-out, combinational.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- result  out  8*NBYTES  sum/difference.
- carry_out  out  1  final carry. For subtract, 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - in_ready = 1.
  - On handshake, capture op_a → a_reg and op_b → b_reg, inverting b_reg when subtracting.
  - carry_reg ← 1 for subtract, 0 for add.
  - idx ← 0, then go to RUN.
- **RUN**
  - add_a = a_reg[8*idx +: 8], add_b = b_reg[8*idx +: 8], add_cin = carry_reg.
  - Each edge: result[8*idx +: 8] ← add_sum, carry_reg ← add_cout, idx ← idx+1.
  - Edge with idx == NBYTES−1: go to DONE.
- **DONE**
  - out_valid = 1; result and flags are stable.
  - On out_valid && out_ready, go to IDLE.
- Flags are registered on the last RUN edge:
  - carry_out = add_cout of the top byte.
  - overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is B after inversion.
  - zero = all result bytes 0, including the byte written on that edge.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- in_ready = 0 in RUN and DONE, so in_valid is ignored there. op_a, op_b and op_sub are sampled only at the handshake.
- Arithmetic is modulo 2^(8*NBYTES). idx is ceil(log2(NBYTES)) bits wide and never wraps past NBYTES−1.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, result = 0, carry_out = 0, overflow = 0, zero = 0, add_a/add_b/add_cin = 0.
- Latency: the handshake edge is E0; out_valid rises after edge E(NBYTES). For NBYTES=4, out_valid is high 4 cycles after accept.
- Minimum issue interval is NBYTES+2 cycles: accept, NBYTES RUN cycles, one DONE cycle with out_ready=1, then IDLE.
- The adder path is purely combinational within one cycle. add_sum/add_cout must settle before the next edge; there is no stall input.
- Reset asserted mid-RUN or mid-DONE: all outputs immediately return to reset values and the in-flight operation is discarded.
- out_ready held low in DONE: result and flags hold indefinitely.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - op_sub selects subtract: b_reg = ~op_b, initial carry_reg = 1.
  - carry_out = 1 means A ≥ B unsigned.
- CLA_SEQ_SUB_EN undefined:
  - op_sub is ignored (add only); b_reg = op_b, initial carry_reg = 0.
  - No inversion logic is synthesized.

## Test plan
- Reset release, then add 0x000000FF + 0x00000001 (NBYTES=4) → result 0x00000100, carry_out 0, overflow 0, zero 0. out_valid exactly 4 cycles after accept; add_cin = 1 observed in the byte-1 cycle.
- Add 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry_out 1, zero 1, overflow 0.
- Add 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, carry_out 0.
- With CLA_SEQ_SUB_EN: 5 − 7 → result 0xFFFFFFFE, carry_out 0, overflow 0.
  - Also 7 − 5 → 0x00000002, carry_out 1.
  - Without the macro, 5 with op_sub=1 and B=7 → 0x0000000C.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands present → result/flags stable, in_ready=0, second request not accepted.
  - Raise out_ready → IDLE next cycle, then the second request is accepted.
- Assert rst_n low during the byte-2 RUN cycle → outputs at reset values immediately.
  - After release, a fresh 0x00000010 + 0x00000020 → 0x00000030 with no stale bytes.
